// File: rtl/quad_pkg.sv
// quad_pkg: register map, CONTROL bit positions, error-count width and quadrature step decode
package quad_pkg;
    localparam logic [1:0] REG_POSITION  = 2'd0;
    localparam logic [1:0] REG_CONTROL   = 2'd1;
    localparam logic [1:0] REG_INDEX_POS = 2'd2;
    localparam logic [1:0] REG_STATUS    = 2'd3;
    localparam int CTRL_DIR     = 0;
    localparam int CTRL_ZERO    = 1;
    localparam int CTRL_CLR_ERR = 2;
    localparam int ERR_W        = 8;
    typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ERR} step_t;
    // {A,B} forward order is 00->01->11->10->00; a change of both phases is illegal
    function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: return STEP_UP;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return STEP_DN;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: return STEP_ERR;
            default:                            return STEP_NONE;
        endcase
    endfunction
endpackage

// File: rtl/multi_quad_decoder_if.sv
// multi_quad_decoder_if: host register bus (address/read/write/data) for multi_quad_decoder
interface multi_quad_decoder_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/quad_channel.sv
// quad_channel: one encoder channel - synchronisers, x4 decoder, position/offset, error and index state
// Optional index capture is built only when INDEX_CAPTURE_EN is defined.
module quad_channel
    import quad_pkg::*;
#(
    parameter int POS_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_a,
    input  logic        i_b,
    input  logic        i_i,
    input  logic        i_wr_ctrl,
    input  logic [2:0]  i_wdata,
    input  logic        i_rd_status,
    output logic [31:0] o_rel,
    output logic [31:0] o_idx_rel,
    output logic [31:0] o_status,
    output logic        o_dir
);
    logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
    logic [1:0]             r_ab_prev;
    logic [POS_WIDTH-1:0]   r_pos, r_off;
    logic                   r_dir, r_last_up, r_err_sticky;
    logic [ERR_W-1:0]       r_err_cnt;
    logic [1:0]             w_ab;
    step_t                  w_step;
    logic [POS_WIDTH-1:0]   w_rel;
    logic                   w_seen;

    assign w_ab     = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    assign w_step   = quad_step(r_ab_prev, w_ab);
    assign w_rel    = r_dir ? r_pos - r_off : r_off - r_pos;
    assign o_rel    = 32'(signed'(w_rel));
    assign o_dir    = r_dir;
    assign o_status = 32'({r_err_cnt, 5'b0, w_seen, r_err_sticky, r_last_up});

    // Synchronise A/B and keep last cycle's synchronised pair as the decode reference
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_sync_a  <= '0;
            r_sync_b  <= '0;
            r_ab_prev <= '0;
        end else begin
            r_sync_a  <= {r_sync_a[SYNC_STAGES-2:0], i_a};
            r_sync_b  <= {r_sync_b[SYNC_STAGES-2:0], i_b};
            r_ab_prev <= w_ab;
        end

    // Position counter: +/-1 per legal step, wraps naturally at POS_WIDTH
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_pos <= '0;
        else if (w_step == STEP_UP)
            r_pos <= r_pos + 1'b1;
        else if (w_step == STEP_DN)
            r_pos <= r_pos - 1'b1;

    // Direction and zero offset from CONTROL (zero takes the pre-step pos), plus last step direction
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_dir     <= 1'b1;
            r_off     <= '0;
            r_last_up <= 1'b0;
        end else begin
            if (i_wr_ctrl) begin
                r_dir <= i_wdata[CTRL_DIR];
                if (i_wdata[CTRL_ZERO])
                    r_off <= r_pos;
            end
            if (w_step == STEP_UP)
                r_last_up <= 1'b1;
            else if (w_step == STEP_DN)
                r_last_up <= 1'b0;
        end

    // Saturating error count and sticky flag; a clear beats a coincident illegal transition
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (i_wr_ctrl && i_wdata[CTRL_CLR_ERR]) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_step == STEP_ERR) begin
            r_err_cnt    <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
            r_err_sticky <= 1'b1;
        end

`ifdef INDEX_CAPTURE_EN
    logic [SYNC_STAGES-1:0] r_sync_i;
    logic                   r_i_prev, r_seen;
    logic [POS_WIDTH-1:0]   r_idx_pos;
    logic                   w_i_rise;

    assign w_i_rise  = r_sync_i[SYNC_STAGES-1] & ~r_i_prev;
    assign w_seen    = r_seen;
    assign o_idx_rel = 32'(signed'(r_idx_pos));

    // Latch the relative position on each synchronised rising edge of I; a new edge beats a STATUS read
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_sync_i  <= '0;
            r_i_prev  <= 1'b0;
            r_idx_pos <= '0;
            r_seen    <= 1'b0;
        end else begin
            r_sync_i <= {r_sync_i[SYNC_STAGES-2:0], i_i};
            r_i_prev <= r_sync_i[SYNC_STAGES-1];
            if (w_i_rise)
                r_idx_pos <= w_rel;
            r_seen <= w_i_rise | (r_seen & ~i_rd_status);
        end
`else
    logic w_unused;
    assign w_unused  = i_i ^ i_rd_status;
    assign w_seen    = 1'b0;
    assign o_idx_rel = '0;
`endif
endmodule

// File: rtl/multi_quad_decoder.sv
// multi_quad_decoder: NUM_CH quadrature decoders behind a {channel, reg} register bus
// Define INDEX_CAPTURE_EN to build per-channel index capture (INDEX_POS, STATUS bit2).
module multi_quad_decoder
    import quad_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int POS_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_quad_decoder_if.slave   bus,
    input  logic [NUM_CH-1:0]     A,
    input  logic [NUM_CH-1:0]     B,
    input  logic [NUM_CH-1:0]     I
);
    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic [ADDR_W-1:0] w_ch;
    logic [1:0]        w_reg;
    logic [31:0]       w_rel    [NUM_CH];
    logic [31:0]       w_idx    [NUM_CH];
    logic [31:0]       w_status [NUM_CH];
    logic [NUM_CH-1:0] w_dir, w_wr_ctrl, w_rd_status;
    logic [31:0]       w_rdata, r_readdata;
    logic              w_unused;

    assign w_ch         = bus.address >> 2;
    assign w_reg        = bus.address[1:0];
    assign bus.readdata = r_readdata;
    assign w_unused     = ^bus.writedata[31:3];

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_wr_ctrl[c]   = bus.write && w_ch == ADDR_W'(c) && w_reg == REG_CONTROL;
            assign w_rd_status[c] = bus.read && w_ch == ADDR_W'(c) && w_reg == REG_STATUS;
            quad_channel #(.POS_WIDTH(POS_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_ch (
                .clk        (clk),
                .reset      (reset),
                .i_a        (A[c]),
                .i_b        (B[c]),
                .i_i        (I[c]),
                .i_wr_ctrl  (w_wr_ctrl[c]),
                .i_wdata    (bus.writedata[2:0]),
                .i_rd_status(w_rd_status[c]),
                .o_rel      (w_rel[c]),
                .o_idx_rel  (w_idx[c]),
                .o_status   (w_status[c]),
                .o_dir      (w_dir[c])
            );
        end
    endgenerate

    // Read mux: addressed channel register, zero for channel indices that do not exist
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (w_ch == ADDR_W'(k))
                w_rdata = (w_reg == REG_POSITION)  ? w_rel[k] :
                          (w_reg == REG_CONTROL)   ? {31'b0, w_dir[k]} :
                          (w_reg == REG_INDEX_POS) ? w_idx[k] : w_status[k];
    end

    // Registered read data: loads on a read strobe and holds until the next one
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_readdata <= '0;
        else if (bus.read)
            r_readdata <= w_rdata;
endmodule

// File: doc/multi_quad_decoder.md
MULTI_QUAD_DECODER -- requirements
Module: multi_quad_decoder

Interface
REQ-001 Parameter NUM_CH, default 4, number of encoder channels (1..16).
REQ-002 Parameter POS_WIDTH, default 32, position counter width (8..32).
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 address  input  $clog2(NUM_CH)+2  {channel, reg[1:0]}.
REQ-007 read  input  1  read strobe.
REQ-008 readdata  output  32  registered read data.
REQ-009 write  input  1  write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 A  input  NUM_CH  encoder phase A per channel, asynchronous.
REQ-012 B  input  NUM_CH  encoder phase B per channel, asynchronous.
REQ-013 I  input  NUM_CH  encoder index per channel, asynchronous.

Function
REQ-014 A/B/I each SHALL pass through SYNC_STAGES flip-flops before use; decode uses the synchronised value and its previous-cycle copy.
REQ-015 x4 decode: Gray sequence 00->01->11->10->00 SHALL increment pos by 1; reverse sequence SHALL decrement by 1; no change SHALL hold.
REQ-016 Transition changing both A and B SHALL leave pos unchanged and increment the channel error count, saturating at 255, and set error sticky.
REQ-017 pos SHALL wrap modulo 2^POS_WIDTH in both directions.
REQ-018 Relative value = dir ? (pos - offset) : (offset - pos), truncated to POS_WIDTH, sign-extended to 32 bits on read.
REQ-019 Reg 0 POSITION: read-only, returns relative value.
REQ-020 Reg 1 CONTROL write: bit0 -> dir; bit1=1 -> offset <= current registered pos; bit2=1 -> clear error count and sticky. Read returns {30'b0, 0, dir}.
REQ-021 Reg 2 INDEX_POS: relative value latched on each synchronised rising edge of I.
REQ-022 Reg 3 STATUS read: bit0 last step direction (1=up), bit1 error sticky, bit2 index seen since last STATUS read, bits[15:8] error count; all other bits 0.
REQ-023 readdata SHALL update one cycle after read is sampled and hold until the next read.
REQ-024 Channel index >= NUM_CH: read returns 0, write ignored.
REQ-025 Read and write in the same cycle to the same register: read returns the pre-write value.
REQ-026 Zero (bit1) coincident with a step: offset takes the pre-step pos; relative reads +/-1 the next cycle.
REQ-027 Error clear coincident with an illegal transition: clear wins, count = 0.
REQ-028 STATUS read coincident with an index edge: the index-seen bit remains set.

Reset
REQ-029 While reset is low: pos, offset, index_pos, error count, sticky flags, index-seen, readdata = 0; dir = 1; synchronisers = 0.
REQ-030 Reset assertion mid-transition SHALL discard that transition; the first post-reset edge decodes against 00.

Configuration
REQ-031 With INDEX_CAPTURE_EN defined: REQ-021 applies, and STATUS bit2 is live.
REQ-032 Without INDEX_CAPTURE_EN: I is unused, reg 2 reads 0, STATUS bit2 = 0, and no index logic is synthesised.

Structure
REQ-033 Package quad_pkg SHALL hold register-index localparams (REG_POSITION..REG_STATUS), CONTROL bit positions, and the error-count width.
REQ-034 Per-channel synchroniser, decoder, counters, and flags SHALL live in sub-module quad_channel, instantiated NUM_CH times; the top holds only the address decode and read mux.

Verification
REQ-035 Reset, then 8 forward Gray steps on ch0 -> POSITION = 8; dir=0 write -> POSITION = 0xFFFFFFF8.
REQ-036 Reverse steps past 0 with POS_WIDTH=16 -> pos wraps to 0xFFFF; POSITION reads 0xFFFFFFFF.
REQ-037 Apply 00->11 three times -> STATUS[15:8] = 3, bit1 = 1, POSITION unchanged; CONTROL bit2 -> STATUS = 0.
REQ-038 Advance 5 steps, write CONTROL 0x3, advance 2 -> POSITION = 2; ch3 unaffected, reads 0.
REQ-039 With INDEX_CAPTURE_EN, pulse I at pos 7 -> INDEX_POS = 7 and STATUS bit2 = 1, cleared after a STATUS read; without the macro, INDEX_POS = 0.
REQ-040 Read at address channel=NUM_CH -> readdata = 0 one cycle later; a write there changes no channel.
